// File: rtl/sim_ctrl_monitor.sv
// sim_ctrl_monitor: MMIO-driven simulation controller with stop/trap drain,
// cycle limit and register-dump record stream.
module sim_ctrl_monitor #(
    parameter logic [31:0] STOP_ADDR      = 32'h6000_0000,
    parameter logic [31:0] TRAP_ADDR      = 32'h6000_0008,
    parameter logic [31:0] REG_DUMP_ADDR  = 32'h6000_0010,
    parameter logic [31:0] FREG_DUMP_ADDR = 32'h6000_0018,
    parameter int unsigned DRAIN_CYCLES   = 50
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mmio_req_i,
    input  logic        mmio_we_i,
    input  logic [31:0] mmio_addr_i,
    input  logic [63:0] mmio_wdata_i,
    input  logic [31:0] simlen_i,
    input  logic        stop_on_trap_i,
    output logic        dump_valid_o,
    output logic        dump_is_fp_o,
    output logic [4:0]  dump_idx_o,
    output logic [63:0] dump_data_o,
    output logic        trap_seen_o,
    output logic [1:0]  state_o,
    output logic        done_o,
    output logic [1:0]  done_cause_o,
    output logic [31:0] cycle_cnt_o
);
    localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2;
    localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYCLES);

    logic [1:0]  r_state, w_next;
    logic [7:0]  r_drain_cnt;
    logic [31:0] r_cycle_cnt;
    logic [4:0]  r_int_idx, r_fp_idx, r_dump_idx;
    logic [1:0]  r_cause;
    logic        r_done, r_trap_seen, r_dump_valid, r_dump_is_fp;
    logic [63:0] r_dump_data;
    logic        w_stop, w_trap, w_idump, w_fdump, w_go_drain, w_lim;
    logic        w_run, w_active, w_rec;

    assign w_stop     = mmio_req_i && mmio_we_i && (mmio_addr_i == STOP_ADDR);
    assign w_trap     = mmio_req_i && (mmio_addr_i == TRAP_ADDR);
    assign w_idump    = mmio_req_i && mmio_we_i && (mmio_addr_i == REG_DUMP_ADDR);
    assign w_fdump    = mmio_req_i && mmio_we_i && (mmio_addr_i == FREG_DUMP_ADDR);
    assign w_go_drain = w_stop || (w_trap && stop_on_trap_i);
    assign w_lim      = (simlen_i != 32'd0) && (r_cycle_cnt == simlen_i - 32'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= RUN;
        else         r_state <= w_next;
    end

    // The cycle limit is a hard ceiling, so it wins over a same-cycle stop.
    always_comb begin
        w_next = DONE;
        if (r_state == RUN)        w_next = w_lim ? DONE : (w_go_drain ? DRAIN : RUN);
        else if (r_state == DRAIN) w_next = (w_lim || r_drain_cnt == 8'd0) ? DONE : DRAIN;
    end

    always_comb begin
        w_run    = r_state == RUN;
        w_active = r_state != DONE;
        w_rec    = w_run && !w_go_drain && (w_idump || w_fdump);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drain_cnt  <= 8'd0;
            r_cycle_cnt  <= 32'd0;
            r_int_idx    <= 5'd1;
            r_fp_idx     <= 5'd0;
            r_cause      <= 2'd0;
            r_done       <= 1'b0;
            r_trap_seen  <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_is_fp <= 1'b0;
            r_dump_idx   <= 5'd0;
            r_dump_data  <= 64'd0;
        end else begin
            if (w_run && w_go_drain && !w_lim)               r_drain_cnt <= DRAIN_INIT;
            else if (r_state == DRAIN && r_drain_cnt != 8'd0) r_drain_cnt <= r_drain_cnt - 8'd1;
            if (w_run && w_lim)           r_cause <= 2'd3;
            else if (w_run && w_go_drain) r_cause <= w_stop ? 2'd1 : 2'd2;
            if (w_active && r_cycle_cnt != 32'hFFFF_FFFF) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_active && w_trap) r_trap_seen <= 1'b1;
            r_done       <= w_next == DONE;
            r_dump_valid <= w_rec;
            if (w_rec) begin
                r_dump_data  <= mmio_wdata_i;
                r_dump_is_fp <= w_fdump;
                r_dump_idx   <= w_fdump ? r_fp_idx : r_int_idx;
            end
            if (w_rec && w_idump) r_int_idx <= r_int_idx + 5'd1;
            if (w_rec && w_fdump) r_fp_idx  <= r_fp_idx + 5'd1;
        end
    end

    assign dump_valid_o = r_dump_valid;
    assign dump_is_fp_o = r_dump_is_fp;
    assign dump_idx_o   = r_dump_idx;
    assign dump_data_o  = r_dump_data;
    assign trap_seen_o  = r_trap_seen;
    assign state_o      = r_state;
    assign done_o       = r_done;
    assign done_cause_o = r_cause;
    assign cycle_cnt_o  = r_cycle_cnt;
endmodule

// File: tb/tb_sim_ctrl_monitor.sv
// tb_sim_ctrl_monitor: directed bench for sim_ctrl_monitor; a second instance
// aliases stop/trap/dump addresses to exercise same-cycle decode priority.
module tb_sim_ctrl_monitor;
    localparam logic [31:0] A_STOP = 32'h6000_0000;
    localparam logic [31:0] A_TRAP = 32'h6000_0008;
    localparam logic [31:0] A_REG  = 32'h6000_0010;
    localparam logic [31:0] A_FREG = 32'h6000_0018;
    localparam logic [31:0] A_ALIAS = 32'h7000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0, we = 1'b0, sot = 1'b0;
    logic [31:0] addr = 32'd0, simlen = 32'd0;
    logic [63:0] wdata = 64'd0;

    logic        dv, dfp, trap_seen, done;
    logic [4:0]  didx;
    logic [63:0] ddata;
    logic [1:0]  state, cause;
    logic [31:0] cnt;
    logic        d2_dv, d2_dfp, d2_trap_seen, d2_done;
    logic [4:0]  d2_didx;
    logic [63:0] d2_ddata;
    logic [1:0]  d2_state, d2_cause;
    logic [31:0] d2_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [4:0] e_idx;

    always #5 clk = ~clk;

    sim_ctrl_monitor u_dut (
        .clk_i(clk), .rst_ni(rst_n), .mmio_req_i(req), .mmio_we_i(we),
        .mmio_addr_i(addr), .mmio_wdata_i(wdata), .simlen_i(simlen), .stop_on_trap_i(sot),
        .dump_valid_o(dv), .dump_is_fp_o(dfp), .dump_idx_o(didx), .dump_data_o(ddata),
        .trap_seen_o(trap_seen), .state_o(state), .done_o(done), .done_cause_o(cause),
        .cycle_cnt_o(cnt)
    );

    sim_ctrl_monitor #(
        .STOP_ADDR(A_ALIAS), .TRAP_ADDR(A_ALIAS), .REG_DUMP_ADDR(A_ALIAS), .DRAIN_CYCLES(3)
    ) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .mmio_req_i(req), .mmio_we_i(we),
        .mmio_addr_i(addr), .mmio_wdata_i(wdata), .simlen_i(simlen), .stop_on_trap_i(sot),
        .dump_valid_o(d2_dv), .dump_is_fp_o(d2_dfp), .dump_idx_o(d2_didx), .dump_data_o(d2_ddata),
        .trap_seen_o(d2_trap_seen), .state_o(d2_state), .done_o(d2_done), .done_cause_o(d2_cause),
        .cycle_cnt_o(d2_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mmio(input logic w, input logic [31:0] a, input logic [63:0] d);
        req = 1'b1; we = w; addr = a; wdata = d;
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 64'd0;
    endtask

    task automatic do_reset(input logic [31:0] sl, input logic st);
        rst_n = 1'b0;
        idle();
        simlen = sl;
        sot = st;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_state"}, 64'(state), 64'd0);
        chk({p, "_done"}, 64'(done), 64'd0);
        chk({p, "_cause"}, 64'(cause), 64'd0);
        chk({p, "_cnt"}, 64'(cnt), 64'd0);
        chk({p, "_dv"}, 64'(dv), 64'd0);
        chk({p, "_dfp"}, 64'(dfp), 64'd0);
        chk({p, "_didx"}, 64'(didx), 64'd0);
        chk({p, "_ddata"}, ddata, 64'd0);
        chk({p, "_trap"}, 64'(trap_seen), 64'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        mmio(1'b1, A_REG, 64'hAAAA_0000_0000_0001); tick();
        chk("dump_a_dv", 64'(dv), 64'd1); chk("dump_a_idx", 64'(didx), 64'd1);
        chk("dump_a_fp", 64'(dfp), 64'd0); chk("dump_a_data", ddata, 64'hAAAA_0000_0000_0001);
        mmio(1'b1, A_REG, 64'hBBBB_0000_0000_0002); tick();
        chk("dump_b_idx", 64'(didx), 64'd2); chk("dump_b_data", ddata, 64'hBBBB_0000_0000_0002);
        mmio(1'b1, A_REG, 64'hCCCC_0000_0000_0003); tick();
        chk("dump_c_idx", 64'(didx), 64'd3); chk("dump_c_data", ddata, 64'hCCCC_0000_0000_0003);
        mmio(1'b1, A_FREG, 64'hDDDD_0000_0000_0004); tick();
        chk("dump_d_dv", 64'(dv), 64'd1); chk("dump_d_idx", 64'(didx), 64'd0);
        chk("dump_d_fp", 64'(dfp), 64'd1); chk("dump_d_data", ddata, 64'hDDDD_0000_0000_0004);
        idle(); tick();
        chk("dump_idle_dv", 64'(dv), 64'd0); chk("dump_hold_data", ddata, 64'hDDDD_0000_0000_0004);
        chk("dump_hold_fp", 64'(dfp), 64'd1);

        mmio(1'b0, A_TRAP, 64'd0); tick(); idle();
        chk("trap_log_seen", 64'(trap_seen), 64'd1); chk("trap_log_state", 64'(state), 64'd0);
        tick();
        chk("trap_log_state2", 64'(state), 64'd0); chk("trap_log_cause", 64'(cause), 64'd0);

        do_reset(32'd0, 1'b0);
        e_idx = 5'd1;
        for (int i = 0; i < 33; i++) begin
            mmio(1'b1, A_REG, {32'hCAFE_0000, 32'(i)}); tick();
            chk("wrap_idx", 64'(didx), 64'(e_idx));
            chk("wrap_data", ddata, {32'hCAFE_0000, 32'(i)});
            e_idx = e_idx + 5'd1;
        end
        idle();
        chk("wrap_last_idx", 64'(didx), 64'd1);

        do_reset(32'd0, 1'b0);
        repeat (100) tick();
        chk("stop100_cnt", 64'(cnt), 64'd100);
        mmio(1'b1, A_STOP, 64'd0); tick(); idle();
        chk("stop100_drain", 64'(state), 64'd1); chk("stop100_cnt101", 64'(cnt), 64'd101);
        chk("stop100_cause", 64'(cause), 64'd1);
        repeat (50) tick();
        chk("stop100_still_drain", 64'(state), 64'd1); chk("stop100_cnt151", 64'(cnt), 64'd151);
        tick();
        chk("stop100_done", 64'(state), 64'd2); chk("stop100_done_o", 64'(done), 64'd1);
        chk("stop100_cnt152", 64'(cnt), 64'd152); chk("stop100_cause_end", 64'(cause), 64'd1);
        mmio(1'b1, A_REG, 64'h1234); tick(); idle();
        chk("done_no_dump", 64'(dv), 64'd0); chk("done_cnt_frozen", 64'(cnt), 64'd152);
        mmio(1'b1, A_STOP, 64'd0); tick(); idle(); tick();
        chk("done_absorbing", 64'(state), 64'd2);

        do_reset(32'd0, 1'b1);
        tick();
        mmio(1'b0, A_TRAP, 64'd0); tick(); idle();
        chk("trapstop_state", 64'(state), 64'd1); chk("trapstop_cause", 64'(cause), 64'd2);
        chk("trapstop_seen", 64'(trap_seen), 64'd1);
        mmio(1'b1, A_REG, 64'h55); tick(); idle();
        chk("drain_no_dump", 64'(dv), 64'd0);
        repeat (4) tick();
        rst_n = 1'b0;
        #1 chk_reset_vals("middrain");
        @(posedge clk);
        #1 rst_n = 1'b1;
        mmio(1'b1, A_STOP, 64'd0); tick(); idle();
        chk("restop_state", 64'(state), 64'd1); chk("restop_cause", 64'(cause), 64'd1);
        chk("restop_cnt", 64'(cnt), 64'd1);
        repeat (51) tick();
        chk("restop_done", 64'(state), 64'd2); chk("restop_cnt_end", 64'(cnt), 64'd52);

        do_reset(32'd200, 1'b0);
        repeat (199) tick();
        chk("simlen_cnt199", 64'(cnt), 64'd199); chk("simlen_run", 64'(state), 64'd0);
        tick();
        chk("simlen_done", 64'(done), 64'd1); chk("simlen_cause", 64'(cause), 64'd3);
        chk("simlen_cnt200", 64'(cnt), 64'd200);
        repeat (3) tick();
        chk("simlen_hold", 64'(cnt), 64'd200);

        do_reset(32'd200, 1'b0);
        repeat (180) tick();
        mmio(1'b1, A_STOP, 64'd0); tick(); idle();
        chk("sl_stop_drain", 64'(state), 64'd1); chk("sl_stop_cnt181", 64'(cnt), 64'd181);
        repeat (18) tick();
        chk("sl_stop_cnt199", 64'(cnt), 64'd199); chk("sl_stop_still", 64'(state), 64'd1);
        tick();
        chk("sl_stop_done", 64'(state), 64'd2); chk("sl_stop_cnt200", 64'(cnt), 64'd200);
        chk("sl_stop_cause", 64'(cause), 64'd1);

        do_reset(32'd0, 1'b1);
        mmio(1'b1, A_ALIAS, 64'h77); tick();
        chk("alias_state", 64'(d2_state), 64'd1); chk("alias_cause", 64'(d2_cause), 64'd1);
        chk("alias_no_dump", 64'(d2_dv), 64'd0); chk("alias_trap", 64'(d2_trap_seen), 64'd1);
        chk("alias_dut1_run", 64'(state), 64'd0);
        mmio(1'b1, A_ALIAS, 64'h88); tick(); idle();
        chk("alias_next_no_dump", 64'(d2_dv), 64'd0); chk("alias_idx_hold", 64'(d2_didx), 64'd0);
        repeat (3) tick();
        chk("alias_done", 64'(d2_state), 64'd2); chk("alias_cause_end", 64'(d2_cause), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
